// File: rtl/cache_refill_ctrl_if.sv
// Data-memory read port used by the refill controller.
// One single-word request per beat, answered by rvalid/rdata.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Load-miss refill for a 4-word-block direct-mapped data cache.
// Fetches the block word by word, then strobes it into the cache.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  hit,
    output logic                  stall,
    cache_refill_ctrl_if.master   mem,
    output logic                  fill_we,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] d0,
    output logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] d2,
    output logic [DATA_WIDTH-1:0] d3,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FILL
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            beat_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] d_q [4];
    logic                  start;
    logic                  capture;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_d      = state_q;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        fill_we      = 1'b0;
        start        = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && !hit) begin
                    start   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {base_q[ADDR_WIDTH-1:4], beat_q, 2'b00};
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                mem.mem_addr = {base_q[ADDR_WIDTH-1:4], beat_q, 2'b00};
                if (mem.mem_rvalid) begin
                    capture = 1'b1;
                    state_d = (beat_q == 2'd3) ? S_FILL : S_ISSUE;
                end
            end
            S_FILL: begin
                fill_we = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Block base, beat index, captured words and miss counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q     <= 2'd0;
            base_q     <= '0;
            miss_count <= '0;
            for (int i = 0; i < 4; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            if (start) begin
                base_q <= {req_addr[ADDR_WIDTH-1:4], 4'b0000};
                beat_q <= 2'd0;
                if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_WIDTH'(1);
                end
            end
            if (capture) begin
                d_q[beat_q] <= mem.mem_rdata;
                if (beat_q != 2'd3) begin
                    beat_q <= beat_q + 2'd1;
                end
            end
        end
    end

    // The miss cycle itself must stall, so this stays combinational
    assign stall     = (state_q != S_IDLE) | (req_valid & ~hit);
    assign fill_addr = base_q;
    assign d0        = d_q[0];
    assign d1        = d_q[1];
    assign d2        = d_q[2];
    assign d3        = d_q[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of refills with
// per-beat memory latency, plus reset, hit and saturation sequences.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        hit;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        fill_we;
    logic [31:0] fill_addr;
    logic [31:0] d0, d1, d2, d3;
    logic [15:0] miss_count;

    logic        s_stall;
    logic        s_fill_we;
    logic [31:0] s_fill_addr;
    logic [31:0] s_d0, s_d1, s_d2, s_d3;
    logic [3:0]  s_miss_count;

    int checks = 0;
    int errors = 0;

    cache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif0 ();
    cache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif1 ();

    assign mif0.mem_rvalid = mem_rvalid;
    assign mif0.mem_rdata  = mem_rdata;
    assign mif1.mem_rvalid = mem_rvalid;
    assign mif1.mem_rdata  = mem_rdata;
    assign mem_req         = mif0.mem_req;
    assign mem_addr        = mif0.mem_addr;

    cache_refill_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
        .stall(stall), .mem(mif0.master),
        .fill_we(fill_we), .fill_addr(fill_addr),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .miss_count(miss_count)
    );

    cache_refill_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
        .stall(s_stall), .mem(mif1.master),
        .fill_we(s_fill_we), .fill_addr(s_fill_addr),
        .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3),
        .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      dbase;
        logic [3:0][3:0]  lat;
        bit               churn;
        bit               spur;
        int               exp_stall;
    } vec_t;

    vec_t tv [4];

    // One refill: drives the miss, acts as memory, checks every beat.
    task automatic run_miss(input logic [31:0] addr,
                            input logic [31:0] dbase,
                            input logic [3:0][3:0] lat,
                            input bit churn,
                            input bit spur,
                            output int stall_cyc,
                            output int fills,
                            output int nreq);
        int          nb;
        int          wcnt;
        bit          waiting;
        bit          filled;
        bit          done;
        logic [31:0] base;
        base      = {addr[31:4], 4'h0};
        nb        = 0;
        nreq      = 0;
        wcnt      = 0;
        waiting   = 0;
        filled    = 0;
        done      = 0;
        stall_cyc = 0;
        fills     = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (c == 0) begin
                req_valid = 1'b1;
                hit       = 1'b0;
                req_addr  = addr;
            end else if (churn && !filled) begin
                req_valid = c[0];
                req_addr  = 32'h0000_2000;
                hit       = 1'b0;
            end else begin
                req_valid = 1'b0;
            end
            if (waiting) begin
                wcnt++;
                if (wcnt == int'(lat[nb])) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = dbase + 32'(nb);
                    nb++;
                    waiting = 0;
                end
            end else if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_0000 + 32'(c);
            end
            #1;
            if (stall) stall_cyc++;
            else if (c > 0) done = 1;
            if (mem_req) begin
                chk("mem_addr", mem_addr, base + 32'(4 * nreq));
                nreq++;
                waiting = 1;
                wcnt    = 0;
            end
            if (fill_we) begin
                fills++;
                filled = 1;
                chk("fill_addr", fill_addr, base);
                chk("d0", d0, dbase);
                chk("d1", d1, dbase + 32'd1);
                chk("d2", d2, dbase + 32'd2);
                chk("d3", d3, dbase + 32'd3);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL refill_timeout: stall still high at addr 0x%0h",
                     addr);
        end
    endtask

    int sc, nf, nr;

    initial begin
        tv[0] = '{32'h0000_1238, 32'h0000_00A0,
                  {4'd1, 4'd1, 4'd1, 4'd1}, 1'b0, 1'b0, 10};
        tv[1] = '{32'h0000_4004, 32'h0000_1000,
                  {4'd1, 4'd5, 4'd1, 4'd3}, 1'b0, 1'b1, 16};
        tv[2] = '{32'h0000_3FFC, 32'h0000_5550,
                  {4'd2, 4'd1, 4'd1, 4'd2}, 1'b1, 1'b0, 12};
        tv[3] = '{32'hFFFF_FFF0, 32'hCAFE_0000,
                  {4'd1, 4'd1, 4'd2, 4'd1}, 1'b0, 1'b1, 11};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        hit        = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_fill_we", fill_we, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_d0", d0, 0);
        chk("rst_fill_addr", fill_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'b1;
            hit       = 1'b1;
            req_addr  = 32'h0000_0100;
            #1;
            chk("hit_stall", stall, 0);
            chk("hit_mem_req", mem_req, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        hit       = 1'b0;
        #1;
        chk("hit_miss_count", miss_count, 0);

        for (int i = 0; i < 4; i++) begin
            run_miss(tv[i].addr, tv[i].dbase, tv[i].lat,
                     tv[i].churn, tv[i].spur, sc, nf, nr);
            chk("stall_cycles", 64'(sc), 64'(tv[i].exp_stall));
            chk("fill_pulses", 64'(nf), 64'd1);
            chk("mem_requests", 64'(nr), 64'd4);
            chk("miss_count", miss_count, 64'(i + 1));
            chk("miss_count_sat", s_miss_count, 64'(i + 1));
        end

        @(negedge clk);
        req_valid = 1'b1;
        hit       = 1'b0;
        req_addr  = 32'h0000_7770;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("abort_issue_req", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_fill_we", fill_we, 0);
        chk("abort_stall", stall, 0);
        chk("abort_miss_count", miss_count, 0);
        chk("abort_d0", d0, 0);
        chk("abort_d1", d1, 0);
        chk("abort_d2", d2, 0);
        chk("abort_d3", d3, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("post_rst_mem_req", mem_req, 0);
            chk("post_rst_stall", stall, 0);
            chk("post_rst_fill_we", fill_we, 0);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        chk("post_rst_d0", d0, 0);

        for (int i = 0; i < 17; i++) begin
            run_miss(32'h0000_0040 + 32'(i * 16), 32'(i * 4),
                     {4'd1, 4'd1, 4'd1, 4'd1}, 1'b0, 1'b0,
                     sc, nf, nr);
        end
        chk("sat_stall_cycles", 64'(sc), 64'd10);
        chk("sat_count_4bit", s_miss_count, 64'd15);
        chk("sat_count_16bit", miss_count, 64'd17);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
